// File: rtl/jk_cmd_sequencer_if.sv
// jk_cmd_sequencer_if: command handshake, flip-flop drive/feedback and status bundle
interface jk_cmd_sequencer_if #(
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH + 1);
    logic          cmd_valid;
    logic [1:0]    cmd_op;
    logic          cmd_ready;
    logic          j;
    logic          k;
    logic          q_fb;
    logic          exp_q;
    logic          synced;
    logic          mismatch;
    logic          busy;
    logic [CW-1:0] count;
    modport master (
        output cmd_valid, cmd_op, q_fb,
        input  cmd_ready, j, k, exp_q, synced, mismatch, busy, count
    );
    modport slave (
        input  cmd_valid, cmd_op, q_fb,
        output cmd_ready, j, k, exp_q, synced, mismatch, busy, count
    );
endinterface

// File: rtl/jk_cmd_sequencer.sv
// jk_cmd_sequencer: FIFO-buffered JK command issuer with q prediction and feedback check
module jk_cmd_sequencer #(
    parameter int DEPTH    = 4,
    parameter int TICK_DIV = 5
) (
    input logic                clk,
    input logic                rst,
    jk_cmd_sequencer_if.slave  bus
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(DEPTH);
    localparam int TW = $clog2(TICK_DIV);
    typedef enum logic [1:0] {IDLE, ISSUE, CHECK} state_t;
    state_t        r_state;
    state_t        w_next;
    logic [TW-1:0] r_tick;
    logic [1:0]    r_fifo [DEPTH];
    logic [AW-1:0] r_wr;
    logic [AW-1:0] r_rd;
    logic [CW-1:0] r_count;
    logic          r_j;
    logic          r_k;
    logic          r_exp_q;
    logic          r_synced;
    logic          r_mismatch;
    logic          w_boundary;
    logic          w_ready;
    logic          w_push;
    logic          w_pop;
    logic          w_issue;
    logic          w_check;

    assign w_boundary = r_tick == TW'(TICK_DIV - 1);
    assign w_ready    = r_count != CW'(DEPTH);
    assign w_push     = bus.cmd_valid && w_ready;
    assign w_pop      = r_state == IDLE && w_boundary && r_count != '0;

    always_ff @(posedge clk)
        r_state <= rst ? IDLE : w_next;

    always_comb
        w_next = r_state == IDLE ? (w_pop ? ISSUE : IDLE) : r_state == ISSUE ? CHECK : IDLE;

    always_comb begin
        w_issue = r_state == ISSUE;
        w_check = r_state == CHECK;
    end

    always_ff @(posedge clk)
        if (w_push) r_fifo[r_wr] <= bus.cmd_op;

    // exp_q follows the issued op on the same edge the flip-flop samples it
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tick     <= '0;
            r_wr       <= '0;
            r_rd       <= '0;
            r_count    <= '0;
            r_j        <= 1'b0;
            r_k        <= 1'b0;
            r_exp_q    <= 1'b0;
            r_synced   <= 1'b0;
            r_mismatch <= 1'b0;
        end else begin
            r_tick  <= w_boundary ? '0 : r_tick + 1'b1;
            r_wr    <= w_push ? r_wr + 1'b1 : r_wr;
            r_rd    <= w_pop ? r_rd + 1'b1 : r_rd;
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
            {r_j, r_k} <= w_pop ? r_fifo[r_rd] : 2'b00;
            if (w_issue) begin
                r_exp_q  <= (r_j && r_k) ? !r_exp_q : (r_j == r_k) ? r_exp_q : r_j;
                r_synced <= r_synced || (r_j != r_k);
            end
            if (w_check && r_synced && bus.q_fb != r_exp_q) r_mismatch <= 1'b1;
        end
    end

    assign bus.cmd_ready = w_ready;
    assign bus.j         = r_j;
    assign bus.k         = r_k;
    assign bus.exp_q     = r_exp_q;
    assign bus.synced    = r_synced;
    assign bus.mismatch  = r_mismatch;
    assign bus.busy      = r_state != IDLE || r_count != '0;
    assign bus.count     = r_count;
endmodule

// File: tb/tb_jk_cmd_sequencer.sv
// tb_jk_cmd_sequencer: vector table, directed slot sequences and a queue-based random model
module tb_jk_cmd_sequencer;
    localparam int DEP = 4;
    localparam int TD  = 13;
    localparam int CW  = $clog2(DEP + 1);
    typedef struct {
        bit       v;
        bit [1:0] op;
        int       cnt;
        bit       rdy;
        bit       j;
        bit       k;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ff_q;
    logic corrupt = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    bit [1:0] mq[$];
    bit [1:0] m_jk;
    int       m_tick;
    int       m_phase;
    bit       m_exp;
    bit       m_sync;
    bit       m_mis;

    always #5 clk = ~clk;

    jk_cmd_sequencer_if #(.DEPTH(DEP)) bus ();
    jk_cmd_sequencer #(.DEPTH(DEP), .TICK_DIV(TD)) dut (.clk(clk), .rst(rst), .bus(bus));

    always_ff @(posedge clk)
        ff_q <= rst ? 1'b0 : (bus.j && bus.k) ? !ff_q : (bus.j == bus.k) ? ff_q : bus.j;
    assign bus.q_fb = ff_q ^ corrupt;

    task automatic chk(string nm, int act, int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.cmd_valid = 1'b0;
        corrupt = 1'b0;
        step();
        rst = 1'b0;
    endtask

    task automatic push(bit [1:0] op);
        bus.cmd_valid = 1'b1;
        bus.cmd_op = op;
        step();
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_pulse(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 2 * TD && !ok; i++) begin
            step();
            ok = bus.j | bus.k;
        end
    endtask

    // Slot-level model: queue of ops, pop on every boundary while idle, issue then check
    task automatic model_step(bit r, bit v, bit [1:0] op, bit qfb);
        bit       boundary;
        bit       full;
        bit       pop;
        bit [1:0] nxt;
        if (r) begin
            mq.delete();
            m_tick = 0; m_phase = 0; m_jk = 2'b00;
            m_exp = 1'b0; m_sync = 1'b0; m_mis = 1'b0;
            return;
        end
        boundary = m_tick == TD - 1;
        full = mq.size() == DEP;
        if (m_phase == 2 && m_sync && qfb != m_exp) m_mis = 1'b1;
        if (m_phase == 1) begin
            case (m_jk)
                2'b01: begin m_exp = 1'b0; m_sync = 1'b1; end
                2'b10: begin m_exp = 1'b1; m_sync = 1'b1; end
                2'b11: m_exp = !m_exp;
                default: ;
            endcase
        end
        pop = m_phase == 0 && boundary && mq.size() > 0;
        nxt = pop ? mq.pop_front() : 2'b00;
        if (v && !full) mq.push_back(op);
        m_phase = pop ? 1 : (m_phase == 1 ? 2 : 0);
        m_jk = nxt;
        m_tick = boundary ? 0 : m_tick + 1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t     tbl[14];
        int       pcyc[$];
        bit       pexp[$];
        bit [1:0] pop_ops[$];
        bit       take_next;
        bit       prev;
        int       dbl;
        bit       mis_seen;
        bit       ok;
        int       pulses;
        logic [9:0] act_v;
        logic [9:0] exp_v;
        bit       r;
        bit       v;
        bit [1:0] op;

        bus.cmd_valid = 1'b0;
        bus.cmd_op = 2'b00;
        step();
        do_reset();
        chk("rst_j", bus.j, 0);
        chk("rst_k", bus.k, 0);
        chk("rst_exp_q", bus.exp_q, 0);
        chk("rst_synced", bus.synced, 0);
        chk("rst_mismatch", bus.mismatch, 0);
        chk("rst_ready", bus.cmd_ready, 1);
        chk("rst_count", bus.count, 0);
        chk("rst_busy", bus.busy, 0);

        // Toggles offered every cycle: fill to DEPTH, hold full, boundary pops one, push refused
        for (int i = 0; i < 14; i++) begin
            tbl[i].v   = i < 13;
            tbl[i].op  = 2'b11;
            tbl[i].cnt = i < 12 ? ((i + 1 < DEP) ? i + 1 : DEP) : DEP - 1;
            tbl[i].rdy = tbl[i].cnt != DEP;
            tbl[i].j   = i == 12;
            tbl[i].k   = i == 12;
        end
        for (int i = 0; i < 14; i++) begin
            bus.cmd_valid = tbl[i].v;
            bus.cmd_op = tbl[i].op;
            step();
            chk($sformatf("tbl%0d_count", i), bus.count, tbl[i].cnt);
            chk($sformatf("tbl%0d_ready", i), bus.cmd_ready, tbl[i].rdy);
            chk($sformatf("tbl%0d_j", i), bus.j, tbl[i].j);
            chk($sformatf("tbl%0d_k", i), bus.k, tbl[i].k);
        end
        bus.cmd_valid = 1'b0;

        do_reset();
        push(2'b10);
        push(2'b11);
        push(2'b01);
        take_next = 1'b0; prev = 1'b0; dbl = 0; mis_seen = 1'b0;
        for (int i = 0; i < 3 * TD + 8; i++) begin
            step();
            if (take_next) pexp.push_back(bus.exp_q);
            take_next = bus.j | bus.k;
            if (take_next) begin
                pcyc.push_back(i);
                pop_ops.push_back({bus.j, bus.k});
            end
            if (take_next && prev) dbl++;
            prev = take_next;
            mis_seen |= bus.mismatch;
        end
        chk("seq_pulse_count", pcyc.size(), 3);
        chk("seq_single_cycle", dbl, 0);
        chk("seq_mismatch", mis_seen, 0);
        chk("seq_synced", bus.synced, 1);
        if (pcyc.size() == 3 && pexp.size() == 3) begin
            chk("seq_first_latency", pcyc[0], TD - 4);
            chk("seq_spacing1", pcyc[1] - pcyc[0], TD);
            chk("seq_spacing2", pcyc[2] - pcyc[1], TD);
            chk("seq_op0", pop_ops[0], 2'b10);
            chk("seq_op1", pop_ops[1], 2'b11);
            chk("seq_op2", pop_ops[2], 2'b01);
            chk("seq_exp0", pexp[0], 1);
            chk("seq_exp1", pexp[1], 0);
            chk("seq_exp2", pexp[2], 0);
        end

        do_reset();
        corrupt = 1'b1;
        push(2'b11);
        for (int i = 0; i < 2 * TD; i++) step();
        chk("unsync_synced", bus.synced, 0);
        chk("unsync_mismatch", bus.mismatch, 0);
        chk("unsync_exp_q", bus.exp_q, 1);
        corrupt = 1'b0;

        do_reset();
        push(2'b10);
        wait_pulse(ok);
        chk("bad_q_pulse_seen", ok, 1);
        corrupt = 1'b1;
        step();
        step();
        corrupt = 1'b0;
        chk("bad_q_mismatch", bus.mismatch, 1);
        chk("bad_q_exp_q", bus.exp_q, 1);
        for (int i = 0; i < 3 * TD; i++) step();
        chk("bad_q_sticky", bus.mismatch, 1);

        do_reset();
        push(2'b10);
        push(2'b10);
        push(2'b10);
        wait_pulse(ok);
        chk("midrst_pulse_seen", ok, 1);
        chk("midrst_queued", bus.count, 2);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst_j", bus.j, 0);
        chk("midrst_k", bus.k, 0);
        chk("midrst_count", bus.count, 0);
        chk("midrst_busy", bus.busy, 0);
        pulses = 0;
        for (int i = 0; i < 3 * TD; i++) begin
            step();
            if (bus.j | bus.k) pulses++;
        end
        chk("midrst_no_pulses", pulses, 0);

        rst = 1'b1;
        bus.cmd_valid = 1'b0;
        corrupt = 1'b0;
        model_step(1'b1, 1'b0, 2'b00, 1'b0);
        step();
        rst = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            r  = $urandom_range(0, 199) == 0;
            v  = $urandom_range(0, 1) == 1;
            op = 2'($urandom);
            corrupt = $urandom_range(0, 149) == 0;
            rst = r;
            bus.cmd_valid = v;
            bus.cmd_op = op;
            model_step(r, v, op, ff_q ^ corrupt);
            step();
            exp_v = {m_jk, CW'(mq.size()), mq.size() != DEP, m_exp, m_sync, m_mis,
                     mq.size() != 0 || m_phase != 0};
            act_v = {bus.j, bus.k, bus.count, bus.cmd_ready, bus.exp_q, bus.synced,
                     bus.mismatch, bus.busy};
            chk($sformatf("rand%0d {j,k,count,ready,exp_q,synced,mismatch,busy}", i), act_v, exp_v);
        end
        rst = 1'b0;
        corrupt = 1'b0;
        bus.cmd_valid = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
